// File: rtl/wb_stage_pipe.sv
// Writeback stage: result select, load formatting, register-file write port,
// jump redirect with a post-jump kill window, and a retired-instruction counter.
module wb_stage_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned RIDX_W = 5,
   parameter int unsigned KILL_N = 2,
   parameter int unsigned CNT_W  = 32,
   localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_sel,
   input  logic [RIDX_W-1:0] in_rd,
   input  logic              in_wen,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_alu,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_load_raw,
   input  logic [2:0]        in_load_fmt,
   input  logic [OFF_W-1:0]  in_byte_off,
   input  logic              in_jump,
   input  logic              rf_stall,
   output logic              rf_we,
   output logic [RIDX_W-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [CNT_W-1:0]  retire_count
);

   localparam int unsigned KW = 3;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("wb_stage_pipe: XLEN must be 32 or 64");
   end

   typedef enum logic {ST_RUN, ST_KILL} state_e;

   state_e              state_q, state_d;
   logic [KW-1:0]       kill_cnt_q, kill_cnt_d;
   logic                rf_we_q, rf_we_d;
   logic [RIDX_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
   logic                redir_v_q, redir_v_d;
   logic [XLEN-1:0]     redir_pc_q, redir_pc_d;
   logic [CNT_W-1:0]    retire_q, retire_d;

   logic [OFF_W-1:0]    off_h, off_w;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [31:0]         lane_w;
   logic [XLEN-1:0]     load_val;
   logic [XLEN-1:0]     result;

   function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r      = {XLEN{sgn & v[7]}};
      r[7:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r       = {XLEN{sgn & v[15]}};
      r[15:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r       = {XLEN{sgn & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   assign in_ready = !rf_stall;

   // Lane extraction and sign/zero extension of the raw load word.
   always_comb begin
      off_h  = in_byte_off & ~OFF_W'(1);
      off_w  = in_byte_off & ~OFF_W'(3);
      lane_b = 8'(in_load_raw >> {in_byte_off, 3'b000});
      lane_h = 16'(in_load_raw >> {off_h, 3'b000});
      lane_w = 32'(in_load_raw >> {off_w, 3'b000});
      load_val = '0;
      case (in_load_fmt)
         3'b000:  load_val = ext8(lane_b, 1'b1);
         3'b001:  load_val = ext16(lane_h, 1'b1);
         3'b010:  load_val = ext32(lane_w, 1'b1);
         3'b011:  load_val = in_load_raw;          // LD; on XLEN=32 the full word is LW
         3'b100:  load_val = ext8(lane_b, 1'b0);
         3'b101:  load_val = ext16(lane_h, 1'b0);
         3'b110:  load_val = ext32(lane_w, 1'b0);  // on XLEN=32 identical to LW
         default: load_val = '0;
      endcase
   end

   // Result source select.
   always_comb begin
      result = in_alu;
      case (in_sel)
         2'b00:   result = in_alu;
         2'b01:   result = load_val;
         2'b10:   result = in_pc + XLEN'(4);
         default: result = in_imm;
      endcase
   end

   // Next-state and output-register logic; a stall freezes everything.
   always_comb begin
      state_d    = state_q;
      kill_cnt_d = kill_cnt_q;
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      redir_v_d  = redir_v_q;
      redir_pc_d = redir_pc_q;
      retire_d   = retire_q;
      if (!rf_stall) begin
         rf_we_d   = 1'b0;
         redir_v_d = 1'b0;
         if (in_valid) begin
            case (state_q)
               ST_RUN: begin
                  rf_we_d    = in_wen && (in_rd != '0);
                  rf_waddr_d = in_rd;
                  rf_wdata_d = result;
                  retire_d   = retire_q + CNT_W'(1);
                  if (in_jump) begin
                     redir_v_d  = 1'b1;
                     redir_pc_d = {in_alu[XLEN-1:1], 1'b0};
                     if (KILL_N != 0) begin
                        state_d    = ST_KILL;
                        kill_cnt_d = KW'(KILL_N);
                     end
                  end
               end
               ST_KILL: begin
                  kill_cnt_d = kill_cnt_q - KW'(1);
                  if (kill_cnt_q <= KW'(1)) begin
                     state_d = ST_RUN;
                  end
               end
               default: state_d = ST_RUN;
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         kill_cnt_q <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         redir_v_q  <= 1'b0;
         redir_pc_q <= '0;
         retire_q   <= '0;
      end else begin
         state_q    <= state_d;
         kill_cnt_q <= kill_cnt_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         redir_v_q  <= redir_v_d;
         redir_pc_q <= redir_pc_d;
         retire_q   <= retire_d;
      end
   end

   assign rf_we          = rf_we_q;
   assign rf_waddr       = rf_waddr_q;
   assign rf_wdata       = rf_wdata_q;
   assign redirect_valid = redir_v_q;
   assign redirect_pc    = redir_pc_q;
   assign retire_count   = retire_q;

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Registered, parametrised RISC-V writeback stage between the memory stage and the register file. Selects the result source (ALU, formatted load data, link address PC+4, or immediate), aligns and sign- or zero-extends load data, and drives a single register-file write port. Issues a one-cycle PC redirect for JAL/JALR and squashes a configurable number of younger beats behind it. Supports back-pressure from the register file and keeps a retired-instruction counter.

## Interface
- XLEN, 32: datapath width; only 32 or 64 are legal.
- RIDX_W, 5: register index width.
- KILL_N, 2: number of accepted beats discarded after a jump, 0..7.
- CNT_W, 32: width of the retire counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; equals !rf_stall.
- in_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- in_rd  in  RIDX_W  destination register.
- in_wen  in  1  instruction writes rd.
- in_pc  in  XLEN  instruction PC.
- in_alu  in  XLEN  ALU result; also the jump target.
- in_imm  in  XLEN  immediate, used for LUI.
- in_load_raw  in  XLEN  raw memory word.
- in_load_fmt  in  3  funct3 of the load.
- in_byte_off  in  log2(XLEN/8)  byte offset of the access within the word.
- in_jump  in  1  JAL or JALR.
- rf_stall  in  1  register file cannot take a write this cycle.
- rf_we  out  1  write enable.
- rf_waddr  out  RIDX_W  write index.
- rf_wdata  out  XLEN  write data.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- retire_count  out  CNT_W  count of retired instructions.

## Operation
- A beat is accepted when in_valid && in_ready.
- Result select:
  - ALU: rf_wdata = in_alu.
  - Immediate: rf_wdata = in_imm.
  - PC+4: rf_wdata = in_pc + 4, modulo 2^XLEN.
  - Load: rf_wdata = formatted in_load_raw.
- Load formats by funct3:
  - 000 LB, 001 LH, 010 LW: sign-extended.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
  - 011 LD: full word.
  - Lane selection: byte = in_load_raw[8*off +: 8]; half = [16*(off>>1) +: 16]; word = [32*(off>>2) +: 32].
  - For XLEN=32, LWU and LD are treated as LW.
  - Illegal fmt 111 produces zero.
- Write suppression: rf_we is forced to 0 when in_rd == 0 or in_wen == 0; rf_waddr and rf_wdata are still loaded.
- Jumps: an accepted beat with in_jump=1 registers redirect_valid=1 and redirect_pc = {in_alu[XLEN-1:1], 1'b0}. Its own link write proceeds normally (in_sel=10 is expected).
- State machine:
  - RUN: normal operation.
  - KILL: entered after an accepted jump when KILL_N>0; kill_cnt is loaded with KILL_N.
  - In KILL, each accepted beat is consumed with no write, no redirect and no count, and kill_cnt decrements. The stage returns to RUN after the beat that takes kill_cnt to 0.
  - in_jump on a killed beat is ignored.
  - With KILL_N=0, KILL is never entered.
- retire_count increments by 1 for each accepted, non-killed beat, whether or not it writes. It wraps modulo 2^CNT_W.

## Timing
- Latency: a beat accepted at edge N appears on rf_we/rf_waddr/rf_wdata/redirect_* during cycle N to N+1.
- rf_we and redirect_valid are 1-cycle pulses per accepted beat. With no accept (in_valid=0) they clear at the next edge.
- rf_stall=1: in_ready=0; all output registers, the FSM and the counter hold, so rf_we stays high if it was high. Outputs resume at the first edge with rf_stall=0.
- Back-to-back jumps: the second jump falls inside the kill window and is discarded. redirect_valid never asserts on consecutive cycles while KILL_N≥1.
- Reset values (asynchronous, take effect immediately): rf_we=0, rf_waddr=0, rf_wdata=0, redirect_valid=0, redirect_pc=0, retire_count=0, state=RUN, kill_cnt=0.
- Reset during KILL aborts the window; the first beat after reset deasserts is processed normally.

## Test plan
- ALU write: in_sel=00, in_rd=5, in_alu=0x1234_5678, accepted at edge N → rf_we=1, waddr=5, wdata=0x12345678 in cycle N+1; rf_we=0 in cycle N+2; retire_count=1.
- Load formats, XLEN=32, raw=0x80FF_7F01:
  - LB off=3 → 0xFFFFFF80.
  - LBU off=1 → 0x0000007F.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=0 → 0x00007F01.
  - fmt 111 → 0.
- JAL: pc=0x100, in_alu=0x201, in_rd=1, KILL_N=2, followed by 3 valid beats each with rd=2 →
  - Cycle after the jump: wdata=0x104, redirect_valid=1, redirect_pc=0x200.
  - The next 2 beats produce no write.
  - The 3rd beat writes x2.
  - retire_count=2.
- x0 suppression: in_rd=0, in_wen=1 → rf_we=0, retire_count increments.
- Stall: assert rf_stall for 3 cycles right after an accepted write → in_ready=0 and rf_we/rf_wdata hold for 3 cycles; a new beat is accepted on the first edge after release.
- Async reset mid-KILL: raise rst between edges → all outputs 0 immediately; after release, the next beat writes normally; retire_count restarts from 0. With CNT_W=4, 17 retirements → retire_count=1.
